// File: rtl/pmbist_march_engine.sv
// pmbist_march_engine: programmable memory BIST march sequencer.
// Buffers up to NUM_INSTR march elements, then executes them one memory op
// per clock against a single-port SRAM, comparing read data one cycle later
// and recording pass/fail, the first failing address/element and a fail count.
module pmbist_march_engine #(
    parameter int ADDR_W       = 8,
    parameter int DATA_W       = 8,
    parameter int ADDR_MAX     = 2**ADDR_W-1,
    parameter int NUM_INSTR    = 4,
    parameter int STOP_ON_FAIL = 0,
    localparam int ELEM_W      = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1,
    localparam int CNT_W       = $clog2(NUM_INSTR + 1),
    localparam int INSTR_W     = DATA_W + 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [INSTR_W-1:0]  instr_in,
    input  logic                instr_we,
    input  logic                instr_clr,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W-1:0]   fail_addr,
    output logic [ELEM_W-1:0]   fail_elem,
    output logic [15:0]         fail_cnt,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic                mem_re,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_next;

    // program buffer and sequencing state
    logic [INSTR_W-1:0] buffer [NUM_INSTR];
    logic [CNT_W-1:0]   cnt;
    logic [ELEM_W-1:0]  pc;
    logic [INSTR_W-1:0] cur_instr;
    logic [ADDR_W-1:0]  addr;
    logic [1:0]         op_idx;

    // one-stage compare pipe carrying the expected word and its tags
    logic               cmp_valid;
    logic [DATA_W-1:0]  cmp_exp;
    logic [ADDR_W-1:0]  cmp_addr;
    logic [ELEM_W-1:0]  cmp_elem;

    // decoded fields of the element being executed
    logic               cur_updwn;
    logic [3:0]         cur_op;
    logic [3:0]         cur_pol;
    logic [1:0]         cur_no;
    logic [DATA_W-1:0]  cur_data;
    logic [INSTR_W-1:0] fetch_word;

    logic               ctrl_ok;
    logic               load_we;
    logic [CNT_W-1:0]   cnt_eff;
    logic               op_bit;
    logic [DATA_W-1:0]  pattern;
    logic               last_op;
    logic               end_addr;
    logic               last_elem;
    logic               issue_rd;
    logic               miscmp;
    logic               stop_now;

    assign cur_updwn  = cur_instr[INSTR_W-1];
    assign cur_op     = cur_instr[DATA_W+9 -: 4];
    assign cur_pol    = cur_instr[DATA_W+5 -: 4];
    assign cur_no     = cur_instr[DATA_W+1 -: 2];
    assign cur_data   = cur_instr[DATA_W-1:0];
    assign fetch_word = buffer[pc];

    // Control inputs are only honoured while no program is running; a push
    // into a full buffer is silently dropped, and clear wins over push.
    assign ctrl_ok  = (state == S_IDLE) || (state == S_DONE);
    assign load_we  = ctrl_ok && instr_we && !instr_clr && (cnt < CNT_W'(NUM_INSTR));
    assign cnt_eff  = load_we ? cnt + CNT_W'(1) : cnt;

    assign op_bit    = cur_op[op_idx];
    assign pattern   = cur_pol[op_idx] ? ~cur_data : cur_data;
    assign last_op   = (op_idx == cur_no);
    assign end_addr  = cur_updwn ? (addr == '0) : (addr == ADDR_W'(ADDR_MAX));
    assign last_elem = (CNT_W'(pc) == cnt - CNT_W'(1));
    assign issue_rd  = (state == S_EXEC) && !op_bit;
    assign miscmp    = cmp_valid && (mem_rdata != cmp_exp);
    assign stop_now  = (STOP_ON_FAIL != 0) && miscmp;

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; an early stop on miscompare overrides normal sequencing
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (instr_clr)
                    state_next = S_IDLE;
                else if (start)
                    state_next = (cnt_eff == '0) ? S_DONE : S_FETCH;
            end
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                if (last_op && end_addr)
                    state_next = last_elem ? S_DRAIN : S_FETCH;
            end
            S_DRAIN: state_next = S_DONE;
            default: state_next = S_IDLE;
        endcase
        if (stop_now)
            state_next = S_DONE;
    end

    // Outputs decoded from state; memory strobes and buses are quiet outside EXEC
    always_comb begin
        busy      = 1'b0;
        done      = 1'b0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            S_FETCH, S_DRAIN: busy = 1'b1;
            S_EXEC: begin
                busy     = 1'b1;
                mem_we   = op_bit;
                mem_re   = !op_bit;
                mem_addr = addr;
                if (op_bit)
                    mem_wdata = pattern;
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
        pass = done && (fail_cnt == '0);
    end

    // Instruction buffer storage; contents are meaningful only below cnt
    always_ff @(posedge clk) begin
        if (load_we)
            buffer[cnt[ELEM_W-1:0]] <= instr_in;
    end

    // Sequencing datapath, compare pipe and fail bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            pc        <= '0;
            cur_instr <= '0;
            addr      <= '0;
            op_idx    <= '0;
            cmp_valid <= 1'b0;
            cmp_exp   <= '0;
            cmp_addr  <= '0;
            cmp_elem  <= '0;
            fail_addr <= '0;
            fail_elem <= '0;
            fail_cnt  <= '0;
        end else begin
            if (ctrl_ok) begin
                if (instr_clr)
                    cnt <= '0;
                else if (load_we)
                    cnt <= cnt + CNT_W'(1);
                if (start && !instr_clr) begin
                    pc        <= '0;
                    fail_addr <= '0;
                    fail_elem <= '0;
                    fail_cnt  <= '0;
                end
            end

            if (state == S_FETCH) begin
                cur_instr <= fetch_word;
                addr      <= fetch_word[INSTR_W-1] ? ADDR_W'(ADDR_MAX) : '0;
                op_idx    <= '0;
            end else if (state == S_EXEC) begin
                if (last_op) begin
                    op_idx <= '0;
                    if (!end_addr)
                        addr <= cur_updwn ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
                    else if (!last_elem)
                        pc <= pc + ELEM_W'(1);
                end else begin
                    op_idx <= op_idx + 2'd1;
                end
            end

            cmp_valid <= issue_rd && !stop_now;
            cmp_exp   <= pattern;
            cmp_addr  <= addr;
            cmp_elem  <= pc;

            if (miscmp) begin
                if (fail_cnt != 16'hFFFF)
                    fail_cnt <= fail_cnt + 16'd1;
                if (fail_cnt == '0) begin
                    fail_addr <= cmp_addr;
                    fail_elem <= cmp_elem;
                end
            end
        end
    end

endmodule
